// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the instruction fetch controller.
//   ADDR_W        - PC / ROM address width
//   INSTR_W       - instruction width
//   fetch_state_t - fetch sequencer states
//   fetch_entry_t - one prefetch FIFO entry: instruction plus the PC it came from
package fetch_pkg;

    localparam int ADDR_W  = 15;
    localparam int INSTR_W = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular prefetch buffer.
//   clk, reset - clock, asynchronous active-low reset
//   push, din  - write din at the tail (ignored when full unless popping)
//   pop        - drop the head (ignored when empty)
//   flush      - discard all entries; overrides push and pop
//   dout       - head entry, all zeros when empty
//   full/empty - occupancy flags
// The pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_q, wr_d;
    logic [PTR_W:0] rd_q, rd_d;
    fetch_entry_t   mem_q [DEPTH];
    logic           wr_en;
    logic           rd_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);

    // A push into a full buffer is only taken together with a pop; the slot
    // written is the one being vacated, and the head is read combinationally
    // before the edge, so the popped value is never corrupted.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (wr_en) wr_d = wr_q + PTR_ONE;
            if (rd_en) rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_q[PTR_W-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the PC, drives the instruction ROM address and
// queues each ROM word into a prefetch FIFO handed to decode.
//   clk, reset         - clock, asynchronous active-low reset
//   imem_addr          - ROM address (the current PC)
//   imem_rd            - ROM data, combinational from imem_addr
//   id_valid/id_ready  - decode handshake: the head transfers on a cycle
//                        where both are high; while id_valid is high and
//                        id_ready low, id_instr/id_pc hold steady
//   id_instr, id_pc    - FIFO head instruction and its PC (zero when empty)
//   redirect_valid/pc  - taken branch: flush the FIFO and load a new PC
//   halt_req           - level request to stop fetching and drain
//   halted             - fetch parked with an empty FIFO
//   dbg_state          - current sequencer state
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               halted,
    output fetch_state_t       dbg_state
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         redir_act;
    fetch_entry_t head;
    fetch_entry_t wr_entry;

    // Redirect wins over everything outside IDLE and suppresses both the
    // pop and the push of that cycle.
    assign redir_act = redirect_valid && (state_q != IDLE);
    assign pop       = !fifo_empty && id_ready && !redir_act;
    assign push      = (state_q == FETCH) && (!fifo_full || pop) && !redir_act;

    assign wr_entry.instr = imem_rd;
    assign wr_entry.pc    = pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redir_act),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redir_act) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redir_act)     state_d = halt_req ? HALTED : FETCH;
                else if (halt_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (redir_act)       state_d = halt_req ? HALTED : FETCH;
                else if (fifo_empty) state_d = HALTED;
            end
            HALTED: begin
                if (redir_act) state_d = halt_req ? HALTED : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = !fifo_empty;
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;
    assign halted    = (state_q == HALTED);
    assign dbg_state = state_q;

endmodule
